// File: rtl/node_port_arbiter.sv
// node_port_arbiter: round-robin share of one node_controller between four ingress ports
// Ports: clk, reset (sync, active-high); req_valid[3:0], req_instr[4*DATA_W-1:0], req_ready[3:0]
//   from/to the link receivers; out_valid, out_ready, instruction_out, source_port to/from
//   node_controller; grant_count, stall_count saturating statistics (only with NODE_ARB_STATS_EN).
// Optional feature macro: NODE_ARB_STATS_EN
module node_port_arbiter #(
    parameter int DATA_W = 32
`ifdef NODE_ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req_valid,
    input  logic [4*DATA_W-1:0] req_instr,
    output logic [3:0]          req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   instruction_out,
    output logic [1:0]          source_port
`ifdef NODE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   grant_count,
    output logic [STAT_W-1:0]   stall_count
`endif
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [1:0] port_q, port_d, last_q, last_d, win, idx;
    logic hit, load;

    assign out_valid = state_q == FULL;
    assign instruction_out = instr_q;
    assign source_port = port_q;
    assign load = ~out_valid | out_ready;
    assign req_ready = (load & hit & ~reset) ? 4'b0001 << win : 4'b0000;

    // Scan from lowest to highest priority so the nearest port after last_q is written last.
    always_comb begin
        win = last_q;
        hit = 1'b0;
        idx = last_q;
        for (int k = 3; k >= 0; k--) begin
            idx = last_q + 2'(k) + 2'd1;
            if (req_valid[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        port_d  = port_q;
        last_d  = last_q;
        if (load) begin
            state_d = hit ? FULL : EMPTY;
            if (hit) begin
                instr_d = req_instr[32'(win)*DATA_W +: DATA_W];
                port_d  = win;
                last_d  = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            instr_q <= '0;
            port_q  <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            port_q  <= port_d;
            last_q  <= last_d;
        end
    end

`ifdef NODE_ARB_STATS_EN
    logic [STAT_W-1:0] grant_q, stall_q;

    assign grant_count = grant_q;
    assign stall_count = stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            stall_q <= '0;
        end else begin
            if (load && hit && !(&grant_q))
                grant_q <= grant_q + 1'b1;
            if (out_valid && !out_ready && !(&stall_q))
                stall_q <= stall_q + 1'b1;
        end
    end
`endif
endmodule
